// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time to an
// external ALU and returns the results in command order.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_a, cmd_b, cmd_op)
//   alu_a/alu_b/alu_op/alu_en registered drive to the ALU
//   alu_result                ALU output, sampled at the end of the enable window
//   res_valid/res_ready       result handshake (res_data, res_op)
//   level                     command FIFO occupancy
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  output logic                     alu_en,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [2:0]               res_op,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } cmd_t;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             fifo_mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop, slot_free;
  logic             issue, capture;

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = issue;
  assign slot_free = !res_valid || res_ready;
  assign head      = fifo_mem[rd_ptr];

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: cmd_op, b: cmd_b, a: cmd_a};
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; issuing only with a free result slot keeps results from being overwritten
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && slot_free) begin
          issue   = 1'b1;
          cnt_d   = CNT_W'(ALU_LAT - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive and result registers; a capture outranks a same-cycle consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else begin
      if (issue) begin
        alu_a  <= head.a;
        alu_b  <= head.b;
        alu_op <= head.op;
        alu_en <= 1'b1;
      end else if (capture) begin
        alu_en <= 1'b0;
      end
      if (capture) begin
        res_data  <= alu_result;
        res_op    <= alu_op;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer, with a bench-side ALU.
// u1 runs with ALU_LAT=1, u3 with ALU_LAT=3; both share clock, reset and operands.
module tb_alu_cmd_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [2:0]       cmd_op;

  logic             v1, rdy1, cr1, en1, rv1;
  logic [WIDTH-1:0] a1, b1, ar1, rd1;
  logic [2:0]       op1, ro1, lvl1;

  logic             v3, rdy3, cr3, en3, rv3;
  logic [WIDTH-1:0] a3, b3, ar3, rd3;
  logic [2:0]       op3, ro3, lvl3;

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign ar1 = alu_fn(a1, b1, op1);
  assign ar3 = alu_fn(a3, b3, op3);

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(cr1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_en(en1), .alu_result(ar1),
    .res_valid(rv1), .res_ready(rdy1), .res_data(rd1), .res_op(ro1), .level(lvl1));

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(cr3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_en(en3), .alu_result(ar3),
    .res_valid(rv3), .res_ready(rdy3), .res_data(rd3), .res_op(ro3), .level(lvl3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    cmd_a  = a;
    cmd_b  = b;
    cmd_op = op;
  endtask

  initial begin
    logic [WIDTH+2:0] exp_q[$];
    int               res_cyc[$];
    logic [WIDTH-1:0] res_val[$];
    int               accepted, en_cnt, rise_at, cyc, bad_rv, bad_en;
    logic             stable;
    logic [WIDTH-1:0] ra, rb, hold;
    logic [2:0]       rop;

    rst = 1'b1; v1 = 1'b0; v3 = 1'b0; rdy1 = 1'b1; rdy3 = 1'b1;
    set_cmd('0, '0, '0);

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cr1), 32'd0);
    chk("rst_level", 32'(lvl1), 32'd0);
    chk("rst_alu_en", 32'(en1), 32'd0);
    chk("rst_res_valid", 32'(rv1), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cr1), 32'd1);
    chk("post_rst_level", 32'(lvl1), 32'd0);

    // single command, ALU_LAT=1
    set_cmd(8'h11, 8'hFF, 3'd0); v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("single_en_before_issue", 32'(en1), 32'd0);
    chk("single_level_queued", 32'(lvl1), 32'd1);
    tick();
    chk("single_en_issue", 32'(en1), 32'd1);
    chk("single_alu_a", 32'(a1), 32'h11);
    chk("single_alu_b", 32'(b1), 32'hFF);
    chk("single_alu_op", 32'(op1), 32'd0);
    chk("single_rv_early", 32'(rv1), 32'd0);
    tick();
    chk("single_en_off", 32'(en1), 32'd0);
    chk("single_rv", 32'(rv1), 32'd1);
    chk("single_res_data", 32'(rd1), 32'h10);
    chk("single_res_op", 32'(ro1), 32'd0);
    tick();
    chk("single_rv_consumed", 32'(rv1), 32'd0);

    // order and throughput
    set_cmd(8'hA9, 8'h90, 3'd1); v1 = 1'b1;
    tick();
    set_cmd(8'h11, 8'hFF, 3'd0);
    chk("order_ready_second", 32'(cr1), 32'd1);
    tick();
    v1 = 1'b0;
    for (int k = 1; k <= 12 && res_val.size() < 2; k++) begin
      tick();
      if (rv1) begin
        res_cyc.push_back(k);
        res_val.push_back(rd1);
      end
    end
    chk("order_count", 32'(res_val.size()), 32'd2);
    if (res_val.size() == 2) begin
      chk("order_first", 32'(res_val[0]), 32'h19);
      chk("order_second", 32'(res_val[1]), 32'h10);
      chk("order_spacing", 32'(res_cyc[1] - res_cyc[0]), 32'd2);
    end

    // backpressure: six offers, five accepted
    tick();
    rdy1 = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(0, 7));
      set_cmd(ra, rb, rop); v1 = 1'b1;
      if (cr1) begin
        accepted++;
        exp_q.push_back({rop, alu_fn(ra, rb, rop)});
      end
      tick();
    end
    v1 = 1'b0;
    chk("bp_accepted", 32'(accepted), 32'd5);
    chk("bp_level", 32'(lvl1), 32'd4);
    chk("bp_cmd_ready", 32'(cr1), 32'd0);
    chk("bp_res_valid", 32'(rv1), 32'd1);
    hold = exp_q[0][WIDTH-1:0];
    chk("bp_res_first", 32'(rd1), 32'(hold));
    tick(); tick(); tick();
    chk("bp_res_held", 32'(rd1), 32'(hold));
    chk("bp_alu_en_idle", 32'(en1), 32'd0);
    chk("bp_level_held", 32'(lvl1), 32'd4);
    rdy1 = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      if (rv1) chk("bp_drain_data", 32'({ro1, rd1}), 32'(exp_q.pop_front()));
      tick();
    end
    chk("bp_drain_left", 32'(exp_q.size()), 32'd0);
    chk("bp_level_empty", 32'(lvl1), 32'd0);

    // ALU_LAT=3: enable window length and latency
    ra = 8'h3C; rb = 8'h05; rop = 3'd1;
    set_cmd(ra, rb, rop); v3 = 1'b1;
    tick();
    v3 = 1'b0;
    en_cnt = 0; rise_at = 0; stable = 1'b1; hold = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (en3) begin
        en_cnt++;
        if (a3 !== ra || b3 !== rb || op3 !== rop) stable = 1'b0;
      end
      if (rv3 && rise_at == 0) begin
        rise_at = k;
        hold = rd3;
      end
    end
    chk("lat3_en_cycles", 32'(en_cnt), 32'd3);
    chk("lat3_stable", 32'(stable), 32'd1);
    chk("lat3_rise_edge", 32'(rise_at), 32'd4);
    chk("lat3_res_data", 32'(hold), 32'(alu_fn(ra, rb, rop)));

    // reset during the second enable cycle
    set_cmd(8'h01, 8'h02, 3'd0); v3 = 1'b1;
    tick();
    set_cmd(8'h03, 8'h04, 3'd2);
    tick();
    set_cmd(8'h05, 8'h06, 3'd3);
    tick();
    v3 = 1'b0;
    chk("mid_exec_en", 32'(en3), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_en", 32'(en3), 32'd0);
    chk("mid_rst_alu_a", 32'(a3), 32'd0);
    chk("mid_rst_alu_op", 32'(op3), 32'd0);
    chk("mid_rst_level", 32'(lvl3), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cr3), 32'd0);
    chk("mid_rst_res_valid", 32'(rv3), 32'd0);
    tick();
    rst = 1'b0;
    bad_rv = 0; bad_en = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rv3) bad_rv++;
      if (en3) bad_en++;
    end
    chk("post_rst_no_result", 32'(bad_rv), 32'd0);
    chk("post_rst_no_issue", 32'(bad_en), 32'd0);
    chk("post_rst_level3", 32'(lvl3), 32'd0);
    chk("post_rst_ready3", 32'(cr3), 32'd1);

    // randomized traffic against an in-order scoreboard
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(0, 7));
      set_cmd(ra, rb, rop);
      v1   = ($urandom_range(0, 99) < 60);
      rdy1 = ($urandom_range(0, 99) < 50);
      if (v1 && cr1) exp_q.push_back({rop, alu_fn(ra, rb, rop)});
      if (rv1 && rdy1) begin
        if (exp_q.size() == 0) chk("rand_unexpected", 32'(rv1), 32'd0);
        else chk("rand_data", 32'({ro1, rd1}), 32'(exp_q.pop_front()));
      end
      tick();
    end
    v1 = 1'b0; rdy1 = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
      if (rv1) chk("rand_drain", 32'({ro1, rd1}), 32'(exp_q.pop_front()));
      tick();
    end
    chk("rand_left", 32'(exp_q.size()), 32'd0);
    chk("rand_level", 32'(lvl1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
